ralu_seq: RTL

Parametrised successor to the 4-bit register/ALU datapath. It holds operand registers A and B, a result register R and a REGS-entry general-purpose register file, all WIDTH bits wide. Each command is a single-cycle op (load, logic/arith, shift, move) or a multi-cycle shift-add multiply, accepted through a valid/ready handshake. It sits between the control unit, which issues commands, and the data bus, which drives `data_in`.

---
 rtl/ralu_seq.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ralu_seq.sv
// ralu_seq: parametrised register/ALU datapath with operand registers A/B,
// result register R, a small register file and a multi-cycle shift-add
// multiplier. Commands arrive over a valid/ready handshake.
module ralu_seq #(
  parameter int WIDTH = 4,
  parameter int REGS  = 8,
  localparam int AW   = (REGS > 1) ? $clog2(REGS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    adr,
  input  logic             wr,
  input  logic             cin,
  input  logic             isl,
  input  logic             isr,
  output logic             osl,
  output logic             osr,
  output logic             cout,
  output logic             zero,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_LDA_IN = 4'd1;
  localparam logic [3:0] OP_LDA_RF = 4'd2;
  localparam logic [3:0] OP_LDB_RF = 4'd3;
  localparam logic [3:0] OP_ADD    = 4'd4;
  localparam logic [3:0] OP_SUB    = 4'd5;
  localparam logic [3:0] OP_AND    = 4'd6;
  localparam logic [3:0] OP_OR     = 4'd7;
  localparam logic [3:0] OP_XOR    = 4'd8;
  localparam logic [3:0] OP_SHL    = 4'd9;
  localparam logic [3:0] OP_SHR    = 4'd10;
  localparam logic [3:0] OP_MUL    = 4'd11;
  localparam logic [3:0] OP_PASSA  = 4'd12;
  localparam logic [3:0] OP_PASSB  = 4'd13;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic               cout_q, cout_d, osl_q, osl_d, osr_q, osr_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [AW-1:0]      adr_q, adr_d;

  logic [WIDTH-1:0]   rf_q [REGS];
  logic [WIDTH-1:0]   rf_rd;
  logic               rf_we;
  logic [AW-1:0]      rf_wadr;
  logic [WIDTH-1:0]   rf_wdata;
  logic [REGS-1:0]    rf_hit;

  logic               accept;
  logic               mul_last;
  logic [WIDTH:0]     sum_add, sum_sub, step_sum;
  logic [WIDTH-1:0]   shl_b, shr_b;
  logic [2*WIDTH-1:0] step_acc;

  assign accept   = cmd_valid && cmd_ready;
  assign mul_last = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));

  // Arithmetic helpers shared by the ALU ops and the multiplier step.
  assign sum_add  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
  assign sum_sub  = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
  assign shl_b    = {b_q[WIDTH-2:0], isl};
  assign shr_b    = {isr, b_q[WIDTH-1:1]};
  // Add into the upper half, then shift the whole accumulator right by one.
  assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign step_acc = {step_sum, acc_q[WIDTH-1:1]};

  // Register-file read: out-of-range addresses read as zero.
  always_comb begin
    rf_rd = '0;
    for (int i = 0; i < REGS; i++) begin
      if (adr == AW'(i)) rf_rd = rf_q[i];
    end
  end

  // Per-entry write decode; an address beyond REGS matches no entry.
  for (genvar gi = 0; gi < REGS; gi++) begin : g_hit
    assign rf_hit[gi] = rf_we && (rf_wadr == AW'(gi));
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: enter MUL on an accepted multiply, leave on the last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && (op == OP_MUL)) state_d = S_MUL;
      S_MUL:   if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: commands are only taken while idle.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
  end

  // Datapath next-state: single-cycle ops in IDLE, one multiply step per MUL cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    cout_d   = cout_q;
    osl_d    = osl_q;
    osr_d    = osr_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    adr_d    = adr_q;
    rf_we    = 1'b0;
    rf_wadr  = adr;
    rf_wdata = r_q;
    if (state_q == S_IDLE) begin
      if (accept) begin
        case (op)
          OP_LDA_IN: a_d = data_in;
          OP_LDA_RF: a_d = rf_rd;
          OP_LDB_RF: b_d = rf_rd;
          OP_ADD:    {cout_d, r_d} = sum_add;
          OP_SUB:    {cout_d, r_d} = sum_sub;
          OP_AND:    r_d = a_q & b_q;
          OP_OR:     r_d = a_q | b_q;
          OP_XOR:    r_d = a_q ^ b_q;
          OP_SHL: begin
            b_d   = shl_b;
            r_d   = shl_b;
            osl_d = b_q[WIDTH-1];
          end
          OP_SHR: begin
            b_d   = shr_b;
            r_d   = shr_b;
            osr_d = b_q[0];
          end
          OP_MUL: begin
            mcand_d  = a_q;
            mplier_d = b_q;
            acc_d    = '0;
            cnt_d    = '0;
            wr_d     = wr;
            adr_d    = adr;
          end
          OP_PASSA:  r_d = a_q;
          OP_PASSB:  r_d = b_q;
          default:   ;
        endcase
        // Multiply defers its write-back to completion.
        if (wr && (op != OP_MUL)) begin
          rf_we    = 1'b1;
          rf_wdata = r_d;
        end
      end
    end else begin
      acc_d    = step_acc;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (mul_last) begin
        a_d      = step_acc[2*WIDTH-1:WIDTH];
        b_d      = step_acc[WIDTH-1:0];
        r_d      = step_acc[WIDTH-1:0];
        done_d   = 1'b1;
        rf_we    = wr_q;
        rf_wadr  = adr_q;
        rf_wdata = step_acc[WIDTH-1:0];
      end
    end
  end

  // Datapath registers; reset clears everything, aborting any multiply.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cout_q   <= 1'b0;
      osl_q    <= 1'b0;
      osr_q    <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      adr_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cout_q   <= cout_d;
      osl_q    <= osl_d;
      osr_q    <= osr_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      adr_q    <= adr_d;
    end
  end

  // Register file storage, cleared by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < REGS; i++) begin
        if (rf_hit[i]) rf_q[i] <= rf_wdata;
      end
    end
  end

  assign result = r_q;
  assign zero   = (r_q == '0);
  assign cout   = cout_q;
  assign osl    = osl_q;
  assign osr    = osr_q;
  assign done   = done_q;

endmodule
